// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16 -> 16 shift-and-add multiplier that time-shares one
// external combinational Hack-style ALU for every add and doubling step.
// Optional feature macro: ALU_MUL_EARLY_EXIT_EN (finish as soon as the
// remaining multiplier bits are all zero).
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] product,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             valid_q, valid_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             last_step;

  // The ALU flags are not needed: zero/negative are derived from the accumulator.
  logic unused_alu_flags;
  assign unused_alu_flags = alu_zr ^ alu_ng;

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last_step = (cnt_q == 4'd15) || (q_q[WIDTH-1:1] == '0);
`else
  assign last_step = (cnt_q == 4'd15);
`endif

  assign ready   = (state_q == IDLE);
  assign valid   = valid_q;
  assign product = product_q;
  assign zr      = zr_q;
  assign ng      = ng_q;

  // State and datapath registers; reset aborts any operation without a valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      zr_q      <= 1'b1;
      ng_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      valid_q   <= valid_d;
      zr_q      <= zr_d;
      ng_q      <= ng_d;
    end
  end

  // Next state: alternate ADD/DBL per multiplier bit, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = ADD;
      ADD:  state_d = DBL;
      DBL:  state_d = last_step ? DONE : ADD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register updates: capture operands, fold ALU results back, latch the result.
  always_comb begin
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    valid_d   = 1'b0;
    zr_d      = zr_q;
    ng_d      = ng_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          m_d   = a;
          q_d   = b;
          cnt_d = '0;
        end
      end
      ADD: acc_d = alu_out;
      DBL: begin
        m_d   = alu_out;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 4'd1;
        if (last_step) begin
          product_d = acc_q;
          zr_d      = (acc_q == '0);
          ng_d      = acc_q[WIDTH-1];
          valid_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ALU drive: acc+m (or acc+0) in ADD, m+m in DBL, constant zero otherwise.
  always_comb begin
    alu_x  = '0;
    alu_y  = '0;
    alu_zx = 1'b1;
    alu_nx = 1'b0;
    alu_zy = 1'b1;
    alu_ny = 1'b0;
    alu_f  = 1'b1;
    alu_no = 1'b0;
    unique case (state_q)
      ADD: begin
        alu_x  = acc_q;
        alu_y  = m_q;
        alu_zx = 1'b0;
        alu_zy = ~q_q[0];
      end
      DBL: begin
        alu_x  = m_q;
        alu_y  = m_q;
        alu_zx = 1'b0;
        alu_zy = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
